// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_bound_chk.sv
// Combinational fetch-window check: in_range for [LO, HI], at_last when addr lies beyond HI.
module pc_bound_chk
    import pc_pkg::*;
#(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] LO   = '0,
    parameter logic [XLEN-1:0] HI   = '0
) (
    input  logic [XLEN-1:0] addr,
    output logic            in_range,
    output logic            at_last
);

    logic [XLEN-1:0] offset;

    // Offset form keeps the lower-bound test meaningful even when LO is zero.
    assign offset   = addr - LO;
    assign in_range = (offset <= (HI - LO));
    assign at_last  = (addr > HI);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with BOOT/RUN/HALT control, redirect, stall and wrap/halt bound.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned redirects and pulses misalign_err.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = '0,
    parameter int              IMEM_BYTES = 84,
    parameter int              WRAP_MODE  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] PCs,
    output logic            pc_valid,
    output logic            halted,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] LAST = RESET_VEC + XLEN'(IMEM_BYTES) - STEP;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] load_target;
    logic            redir_take;
    logic            pc_in_range, pc_at_last;
    logic            seq_in_range, seq_over;
    logic            unused_bits;

    assign pc_seq = pc_q + STEP;

    pc_bound_chk #(.XLEN(XLEN), .LO(RESET_VEC), .HI(LAST)) u_chk_pc (
        .addr     (pc_q),
        .in_range (pc_in_range),
        .at_last  (pc_at_last)
    );

    pc_bound_chk #(.XLEN(XLEN), .LO(RESET_VEC), .HI(LAST)) u_chk_seq (
        .addr     (pc_seq),
        .in_range (seq_in_range),
        .at_last  (seq_over)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic target_ok;
    logic mis_q, mis_d;

    assign target_ok   = (redirect_target[1:0] == 2'b00);
    assign load_target = redirect_target;
    assign redir_take  = redirect_valid && target_ok && (state_q != BOOT);
    assign mis_d       = redirect_valid && !target_ok && (state_q != BOOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mis_q <= 1'b0;
        else       mis_q <= mis_d;
    end

    assign misalign_err = mis_q;
`else
    assign load_target  = {redirect_target[XLEN-1:2], 2'b00};
    assign redir_take   = redirect_valid && (state_q != BOOT);
    assign misalign_err = 1'b0;
`endif

    assign unused_bits = ^{pc_at_last, seq_in_range, redirect_target[1:0]};

    // NOTE: defaults first so every path assigns state_d/pc_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (redir_take) begin
                    pc_d = load_target;
                end else if (!stall) begin
                    if (seq_over) begin
                        if (WRAP_MODE != 0) pc_d    = RESET_VEC;
                        else                state_d = HALT;
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            HALT: begin
                if (redir_take) begin
                    pc_d    = load_target;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign PCs      = pc_q;
    assign pc_valid = (state_q == RUN) && pc_in_range;
    assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench: wrapping instance driven from a vector table, halting instance by hand sequences.
module tb_pc_gen;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        valid;
        logic        mis;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_w = 1'b0, rv_w = 1'b0;
    logic [31:0] tgt_w = '0;
    logic [31:0] pc_w;
    logic        valid_w, halted_w, mis_w;
    logic        stall_h = 1'b0, rv_h = 1'b0;
    logic [31:0] tgt_h = '0;
    logic [31:0] pc_h;
    logic        valid_h, halted_h, mis_h;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_gen #(.WRAP_MODE(1)) u_wrap (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall_w),
        .redirect_valid  (rv_w),
        .redirect_target (tgt_w),
        .PCs             (pc_w),
        .pc_valid        (valid_w),
        .halted          (halted_w),
        .misalign_err    (mis_w)
    );

    pc_gen #(.WRAP_MODE(0)) u_halt (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall_h),
        .redirect_valid  (rv_h),
        .redirect_target (tgt_h),
        .PCs             (pc_h),
        .pc_valid        (valid_h),
        .halted          (halted_h),
        .misalign_err    (mis_h)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic s, input logic r, input logic [31:0] t,
                           input logic [31:0] p, input logic v, input logic m);
        vec_t e;
        e.stall = s; e.rv = r; e.tgt = t; e.pc = p; e.valid = v; e.mis = m;
        vecs.push_back(e);
    endtask

    task automatic step_h(input string tag, input logic s, input logic r, input logic [31:0] t,
                          input logic [31:0] epc, input logic ev, input logic eh);
        stall_h = s; rv_h = r; tgt_h = t;
        @(posedge clk);
        #1;
        check({tag, " pc"}, pc_h, epc);
        check({tag, " valid"}, 32'(valid_h), 32'(ev));
        check({tag, " halted"}, 32'(halted_h), 32'(eh));
        check({tag, " mis"}, 32'(mis_h), 32'd0);
        stall_h = 1'b0; rv_h = 1'b0; tgt_h = '0;
    endtask

    initial begin
        // stall, redirect, target, expected PC, pc_valid, misalign_err
        add_vec(0, 1, 32'd40,  32'd0,  1, 0);   // redirect in BOOT ignored
        add_vec(0, 0, 32'd0,   32'd4,  1, 0);
        add_vec(0, 0, 32'd0,   32'd8,  1, 0);
`ifdef PC_ALIGN_CHECK_EN
        add_vec(0, 1, 32'd42,  32'd12, 1, 1);
`else
        add_vec(0, 1, 32'd42,  32'd40, 1, 0);
`endif
        add_vec(0, 1, 32'd20,  32'd20, 1, 0);
        add_vec(1, 1, 32'd40,  32'd40, 1, 0);   // redirect beats stall
        add_vec(1, 0, 32'd0,   32'd40, 1, 0);
        add_vec(1, 0, 32'd0,   32'd40, 1, 0);
        add_vec(1, 0, 32'd0,   32'd40, 1, 0);
        add_vec(0, 0, 32'd0,   32'd44, 1, 0);
        add_vec(0, 1, 32'd72,  32'd72, 1, 0);
        add_vec(0, 0, 32'd0,   32'd76, 1, 0);
        add_vec(0, 0, 32'd0,   32'd80, 1, 0);
        add_vec(0, 0, 32'd0,   32'd0,  1, 0);   // wrap past LAST
        add_vec(0, 0, 32'd0,   32'd4,  1, 0);
        add_vec(0, 1, 32'd200, 32'd200, 0, 0);  // out-of-range target loaded
        add_vec(0, 0, 32'd0,   32'd0,  1, 0);
`ifdef PC_ALIGN_CHECK_EN
        add_vec(0, 1, 32'h1FF, 32'd4,  1, 1);
`else
        add_vec(0, 1, 32'h1FF, 32'h1FC, 0, 0);
`endif
        add_vec(0, 1, 32'd80,  32'd80, 1, 0);
        add_vec(1, 0, 32'd0,   32'd80, 1, 0);
        add_vec(0, 0, 32'd0,   32'd0,  1, 0);
        add_vec(0, 1, 32'd60,  32'd60, 1, 0);

        #12;
        check("reset pc", pc_w, 32'd0);
        check("reset valid", 32'(valid_w), 32'd0);
        check("reset halted", 32'(halted_w), 32'd0);
        check("reset mis", 32'(mis_w), 32'd0);
        reset = 1'b0;
        #1;
        check("boot pc", pc_w, 32'd0);
        check("boot valid", 32'(valid_w), 32'd0);

        foreach (vecs[i]) begin
            stall_w = vecs[i].stall; rv_w = vecs[i].rv; tgt_w = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("v%0d pc", i), pc_w, vecs[i].pc);
            check($sformatf("v%0d valid", i), 32'(valid_w), 32'(vecs[i].valid));
            check($sformatf("v%0d halted", i), 32'(halted_w), 32'd0);
            check($sformatf("v%0d mis", i), 32'(mis_w), 32'(vecs[i].mis));
        end
        stall_w = 1'b0; rv_w = 1'b0; tgt_w = '0;

        // Asynchronous reset in the middle of a cycle while PCs = 60.
        #3;
        reset = 1'b1;
        #1;
        check("midrst pc", pc_w, 32'd0);
        check("midrst valid", 32'(valid_w), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        step_h("h boot",   0, 0, 32'd0,  32'd0,  1, 0);
        step_h("h redir",  0, 1, 32'd76, 32'd76, 1, 0);
        step_h("h last",   0, 0, 32'd0,  32'd80, 1, 0);
        step_h("h halt",   0, 0, 32'd0,  32'd80, 0, 1);
        step_h("h stall",  1, 0, 32'd0,  32'd80, 0, 1);
        step_h("h hold",   0, 0, 32'd0,  32'd80, 0, 1);
        step_h("h resume", 0, 1, 32'd16, 32'd16, 1, 0);
        step_h("h run",    0, 0, 32'd0,  32'd20, 1, 0);
        step_h("h to80",   0, 1, 32'd80, 32'd80, 1, 0);
        step_h("h halt2",  0, 0, 32'd0,  32'd80, 0, 1);

        // Asynchronous reset while halted.
        #3;
        reset = 1'b1;
        #1;
        check("hrst pc", pc_h, 32'd0);
        check("hrst valid", 32'(valid_h), 32'd0);
        check("hrst halted", 32'(halted_h), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #20;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32: width of the program counter and target buses.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000: address loaded on reset and on wrap.
REQ-003 Parameter IMEM_BYTES, default 84: instruction memory size in bytes; last legal fetch address LAST = RESET_VEC + IMEM_BYTES - 4.
REQ-004 Parameter WRAP_MODE, default 1: 1 = wrap to RESET_VEC past LAST; 0 = halt past LAST.
REQ-005 clk  input  1  single clock, rising-edge active.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 stall  input  1  hold current PC this cycle.
REQ-008 redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 redirect_target  input  XLEN  branch/jump destination.
REQ-010 PCs  output  XLEN  current fetch address (registered).
REQ-011 pc_valid  output  1  PCs is a legal fetch address this cycle.
REQ-012 halted  output  1  block is in HALT state.
REQ-013 misalign_err  output  1  one-cycle pulse: misaligned redirect rejected.

Function
REQ-014 The block SHALL implement states BOOT, RUN, HALT.
REQ-015 BOOT SHALL last exactly one clk after reset deasserts, then go to RUN; PCs = RESET_VEC, pc_valid = 0 in BOOT.
REQ-016 In RUN, pc_valid SHALL be 1 and next-PC priority SHALL be: redirect_valid > stall > bound check > PCs + 4.
REQ-017 An accepted redirect SHALL load redirect_target into PCs on the next clk regardless of stall.
REQ-018 stall without redirect SHALL hold PCs and state unchanged.
REQ-019 When PCs + 4 > LAST (unsigned, XLEN-bit, carry discarded) and no redirect/stall: WRAP_MODE=1 loads RESET_VEC; WRAP_MODE=0 holds PCs, enters HALT.
REQ-020 In HALT, pc_valid SHALL be 0, halted SHALL be 1, PCs SHALL hold; stall is ignored.
REQ-021 An accepted redirect in HALT SHALL load the target and return to RUN on the same clk edge.
REQ-022 Redirect targets outside [RESET_VEC, LAST] SHALL be loaded; pc_valid SHALL be 0 while PCs is out of range.
REQ-023 Redirect in BOOT SHALL be ignored.

Reset
REQ-024 Asserting reset SHALL immediately (asynchronously) set PCs = RESET_VEC, state = BOOT, pc_valid = 0, halted = 0, misalign_err = 0, including mid-redirect or mid-HALT.

Configuration
REQ-025 Macro PC_ALIGN_CHECK_EN defined: a redirect with redirect_target[1:0] != 0 SHALL be ignored (normal RUN/HALT behaviour applies as if no redirect) and misalign_err SHALL pulse high for one clk.
REQ-026 Macro PC_ALIGN_CHECK_EN undefined: redirect_target[1:0] SHALL be forced to 0 on load and misalign_err SHALL be tied 0.

Structure
REQ-027 Package pc_pkg SHALL hold the state enum (BOOT, RUN, HALT) and the constant PC_STEP = 4.
REQ-028 Range/bound comparison SHALL live in combinational sub-module pc_bound_chk (inputs addr, outputs in_range, at_last); pc_gen instantiates it twice (PCs, PCs + 4).

Verification
REQ-029 Reset pulse then release, no stimulus: PCs 0 for 2 clks (BOOT, then RUN pc_valid=1), then 4, 8, 12 ...
REQ-030 WRAP_MODE=1, IMEM_BYTES=84: free run reaches 80, next clk PCs = 0, pc_valid stays 1.
REQ-031 WRAP_MODE=0: PCs reaches 80, next clk halted=1, pc_valid=0, PCs=80; redirect to 16 -> PCs=16, RUN, pc_valid=1.
REQ-032 RUN at PCs=20, stall=1 and redirect_valid=1 target 40 same cycle -> PCs=40 next clk; stall alone at 40 for 3 clks -> PCs stays 40.
REQ-033 PC_ALIGN_CHECK_EN defined, redirect target 42 at PCs=8 -> PCs=12, misalign_err=1 for one clk; undefined -> PCs=40, misalign_err=0.
REQ-034 Reset asserted mid-clock while PCs=60 -> PCs=0, pc_valid=0 before next clk edge.
